// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan driver and its downstream decoder.
package seg_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // One-hot vector with bit idx set, or all zero when idx is out of range.
    function automatic logic [7:0] onehot(input int unsigned idx, input int unsigned n);
        logic [7:0] r;
        r = '0;
        if (idx < n && idx < 8) r = 8'(1) << idx;
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display bus between the frame source (master) and the scan driver (slave).
interface seg_scan_driver_if
    import seg_pkg::*;
#(
    parameter int DIGITS = 4
);

    logic [NIBBLE_W*DIGITS-1:0] data_in;
    logic                       load;
    logic                       blank_leading;
    nibble_t                    hex_out;
    logic [DIGITS-1:0]          digit_en;
    logic                       frame_done;

    modport master (
        output data_in, load, blank_leading,
        input  hex_out, digit_en, frame_done
    );

    modport slave (
        input  data_in, load, blank_leading,
        output hex_out, digit_en, frame_done
    );

endinterface

// File: rtl/seg_scan_timer.sv
// Slot counter and digit index for the scanner; exposes next-state values so
// the output registers can update on the same edge as the counters.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DIGITS   = 4,
    localparam int CNT_W   = $clog2(SCAN_DIV),
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt_n,
    output logic [IDX_W-1:0] idx_n,
    output logic             tick,
    output logic             bnd
);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    // Next-state decode: wrap the slot counter on tick, advance the digit index.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        tick  = (cnt == CNT_W'(SCAN_DIV - 1));
        bnd   = tick && (idx == IDX_W'(DIGITS - 1));
        cnt_n = cnt + CNT_W'(1);
        idx_n = idx;
        if (tick) begin
            cnt_n = '0;
            idx_n = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

    // Counter registers.
    // NOTE: state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_n;
            idx <= idx_n;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit hex scanner with tear-free frame updates, a dead band
// at the start of each slot and optional leading-zero blanking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_driver_if.slave  bus
);

    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int WORD_W = NIBBLE_W * DIGITS;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("seg_scan_driver: DIGITS must be 1..8");
    end
    if (SCAN_DIV < 2 || SCAN_DIV <= DEAD_CYCLES) begin : g_bad_div
        $error("seg_scan_driver: SCAN_DIV must be >= 2 and > DEAD_CYCLES");
    end
    if (DEAD_CYCLES < 0) begin : g_bad_dead
        $error("seg_scan_driver: DEAD_CYCLES must be >= 0");
    end

    logic [CNT_W-1:0]  cnt_n;
    logic [IDX_W-1:0]  idx_n;
    logic              tick;
    logic              bnd;

    logic [WORD_W-1:0] pending;
    logic              pend_v;
    logic [WORD_W-1:0] shadow;
    logic [WORD_W-1:0] shadow_n;
    logic              blank_q;
    logic              blank_q_n;
    logic [DIGITS-1:0] blank;
    logic [DIGITS-1:0] en_n;
    nibble_t           hex_n;
    logic [7:0]        sel;
    logic              all_zero;

    seg_scan_timer #(
        .SCAN_DIV (SCAN_DIV),
        .DIGITS   (DIGITS)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt_n (cnt_n),
        .idx_n (idx_n),
        .tick  (tick),
        .bnd   (bnd)
    );

    // Frame-level next state: the displayed word and blanking mode only change at a boundary.
    always_comb begin
        shadow_n  = shadow;
        blank_q_n = blank_q;
        if (bnd) begin
            if (pend_v) shadow_n = pending;
            blank_q_n = bus.blank_leading;
        end
    end

    // Blank mask: digit i>0 is dark when it and every more significant nibble are zero.
    always_comb begin
        blank    = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero && (shadow_n[i*NIBBLE_W +: NIBBLE_W] == '0);
            blank[i] = blank_q_n && all_zero;
        end
    end

    // Next output values, taken from next-state counters so outputs align with cnt/idx.
    always_comb begin
        en_n  = '0;
        hex_n = '0;
        sel   = onehot(32'(idx_n), DIGITS);
        if (int'(cnt_n) >= DEAD_CYCLES && !blank[idx_n]) begin
            en_n  = sel[DIGITS-1:0];
            hex_n = shadow_n[idx_n*NIBBLE_W +: NIBBLE_W];
        end
    end

    // Pending word: a load written in the boundary cycle survives into the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            pend_v  <= 1'b0;
        end else begin
            if (bnd) pend_v <= 1'b0;
            if (bus.load) begin
                pending <= bus.data_in;
                pend_v  <= 1'b1;
            end
        end
    end

    // Displayed word and blanking mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            blank_q <= 1'b0;
        end else begin
            shadow  <= shadow_n;
            blank_q <= blank_q_n;
        end
    end

    // Registered outputs so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.digit_en   <= '0;
            bus.hex_out    <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.digit_en   <= en_n;
            bus.hex_out    <= hex_n;
            bus.frame_done <= bnd;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-level model predicts every cycle's
// outputs, a negedge monitor pops and compares them.
module tb_seg_scan_driver;
    import seg_pkg::*;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int DEAD     = 2;
    localparam int FRAME    = SCAN_DIV * DIGITS;

    typedef struct {
        logic [DIGITS-1:0] en;
        logic [3:0]        hex;
        logic              fd;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_driver #(
        .DIGITS      (DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 1'b0;
    logic        prev_fd = 1'b0;

    // Reference model state: edges since reset release, the word on display,
    // the most recent undisplayed load, and the blanking mode of the current frame.
    int          e = 0;
    logic [15:0] shown = '0;
    logic [15:0] pend = '0;
    bit          has_pend = 1'b0;
    bit          blank_m = 1'b0;
    bit          cur_bl = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // What the display shows right after edge n, from the scan rules alone.
    function automatic exp_t model_out(input int n, input logic [15:0] w, input bit bl);
        exp_t r;
        int pos = n % SCAN_DIV;
        int dig = (n / SCAN_DIV) % DIGITS;
        int sig = 1;
        for (int i = 0; i < DIGITS; i++)
            if (((w >> (4 * i)) & 16'hF) != 0) sig = i + 1;
        r.fd  = (n % FRAME == 0);
        r.en  = '0;
        r.hex = '0;
        if (pos >= DEAD && !(bl && dig >= sig)) begin
            r.en  = DIGITS'(1 << dig);
            r.hex = 4'((w >> (4 * dig)) & 16'hF);
        end
        return r;
    endfunction

    // Drive one cycle of inputs, advance the model over the edge, queue the prediction.
    task automatic step(input bit ld, input logic [15:0] d, input bit bl);
        bus.load          = ld;
        bus.data_in       = d;
        bus.blank_leading = bl;
        @(posedge clk);
        e++;
        if (e % FRAME == 0) begin
            if (has_pend) shown = pend;
            has_pend = 1'b0;
            blank_m  = bl;
        end
        if (ld) begin
            pend     = d;
            has_pend = 1'b1;
        end
        sb_q.push_back(model_out(e, shown, blank_m));
        #1;
        bus.load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'($urandom), cur_bl);
    endtask

    // Idle until the next edge lands at the given position within a frame.
    task automatic align(input int pos);
        while ((e + 1) % FRAME != pos) idle(1);
    endtask

    task automatic model_reset();
        e        = 0;
        shown    = '0;
        pend     = '0;
        has_pend = 1'b0;
        blank_m  = 1'b0;
        prev_fd  = 1'b0;
    endtask

    // Monitor: compare every cycle's outputs against the queued prediction.
    always @(negedge clk) begin
        exp_t x;
        if (mon_en) begin
            check("digit_en_onehot0", 32'($onehot0(bus.digit_en)), 32'd1);
            if (bus.digit_en == '0) check("hex_when_dark", 32'(bus.hex_out), 32'd0);
            if (prev_fd) check("frame_done_double", 32'(bus.frame_done), 32'd0);
            prev_fd = bus.frame_done;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check("digit_en", 32'(bus.digit_en), 32'(x.en));
                check("hex_out", 32'(bus.hex_out), 32'(x.hex));
                check("frame_done", 32'(bus.frame_done), 32'(x.fd));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load          = 1'b0;
        bus.data_in       = '0;
        bus.blank_leading = 1'b0;
        #1 rst_n = 1'b0;
        #11;
        check("reset_digit_en", 32'(bus.digit_en), 32'd0);
        check("reset_hex_out", 32'(bus.hex_out), 32'd0);
        check("reset_frame_done", 32'(bus.frame_done), 32'd0);

        // Release away from the edge; the first edge afterwards is model edge 1.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // Free-running scan of the reset word.
        idle(2 * FRAME);

        // Mid-frame load shows only from the next frame.
        align(10);
        step(1'b1, 16'h1234, cur_bl);
        idle(2 * FRAME);

        // Two loads within a frame: only the last one is ever shown.
        align(5);
        step(1'b1, 16'hABCD, cur_bl);
        idle(3);
        step(1'b1, 16'h5678, cur_bl);
        idle(2 * FRAME);

        // Load in the boundary cycle lands one frame later.
        align(0);
        step(1'b1, 16'h9999, cur_bl);
        idle(2 * FRAME);

        // Leading-zero blanking.
        cur_bl = 1'b1;
        align(7);
        step(1'b1, 16'h0050, cur_bl);
        idle(2 * FRAME);
        step(1'b1, 16'h0000, cur_bl);
        idle(2 * FRAME);
        step(1'b1, 16'h0100, cur_bl);
        idle(2 * FRAME);

        // Random loads and blanking changes, including mid-frame toggles.
        repeat (600) begin
            if ($urandom_range(0, 19) == 0) cur_bl = ~cur_bl;
            step($urandom_range(0, 15) == 0, 16'($urandom_range(0, 3) == 0 ? ($urandom & 32'h00FF) : $urandom), cur_bl);
        end

        // Asynchronous reset mid-slot with a load still pending.
        cur_bl = 1'b0;
        align(1);
        step(1'b1, 16'hBEEF, cur_bl);
        while (!(e % SCAN_DIV == 5 && (e / SCAN_DIV) % DIGITS == 2)) idle(1);
        mon_en = 1'b0;
        sb_q.delete();
        rst_n = 1'b0;
        #1;
        check("async_rst_digit_en", 32'(bus.digit_en), 32'd0);
        check("async_rst_hex_out", 32'(bus.hex_out), 32'd0);
        check("async_rst_frame_done", 32'(bus.frame_done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("held_rst_digit_en", 32'(bus.digit_en), 32'd0);
        check("held_rst_hex_out", 32'(bus.hex_out), 32'd0);
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        idle(2 * FRAME + 5);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
